// File: rtl/pc_branch_sequencer_pkg.sv
// pc_branch_sequencer_pkg: shared state encoding and instruction-size constants
package pc_branch_sequencer_pkg;
  typedef enum logic [1:0] {BOOT, RUN, PEND} seq_state_t;
  localparam int INSTR_SHIFT = 2;
  localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/pc_branch_sequencer_target.sv
// pc_branch_sequencer_target: branch target = br_pc + word offset, wrapping mod 2^ADDR_W
module branch_target_adder
  import pc_branch_sequencer_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  output logic [ADDR_W-1:0] tgt
);
  assign tgt = br_pc + (br_offset << INSTR_SHIFT);
endmodule

// File: rtl/pc_branch_sequencer.sv
// pc_branch_sequencer: fetch PC owner, branch redirect sequencing and pipeline flush
module pc_branch_sequencer
  import pc_branch_sequencer_pkg::*;
#(
  parameter int                ADDR_W       = 64,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              flush,
  output logic [CNT_W-1:0]  taken_cnt
);
  seq_state_t        state;
  logic [ADDR_W-1:0] pend_tgt;
  logic [ADDR_W-1:0] tgt;
  logic              take;
  branch_target_adder #(.ADDR_W(ADDR_W)) u_adder (
    .br_pc    (br_pc),
    .br_offset(br_offset),
    .tgt      (tgt)
  );
  assign take     = br_valid & br_taken & (state != BOOT);
  assign flush    = take;
  // In PEND the held pc is wrong-path, so only RUN marks it fetchable
  assign pc_valid = (state == RUN);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BOOT;
      pc        <= RESET_VECTOR;
      pend_tgt  <= '0;
      taken_cnt <= '0;
    end else begin
      if (take && !(&taken_cnt)) taken_cnt <= taken_cnt + 1'b1;
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (take && stall) begin
            pend_tgt <= tgt;
            state    <= PEND;
          end else if (take) pc <= tgt;
          else if (!stall) pc <= pc + ADDR_W'(INSTR_BYTES);
        end
        PEND: begin
          if (take) pend_tgt <= tgt;
          if (!stall) begin
            pc    <= take ? tgt : pend_tgt;
            state <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_branch_sequencer.sv
// tb_pc_branch_sequencer: directed vector table, corner sequences and random run against a reference model
module tb_pc_branch_sequencer;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;
  logic              clk = 0;
  logic              reset = 1;
  logic              stall = 0, br_valid = 0, br_taken = 0;
  logic [63:0]       br_pc = '0, br_offset = '0;
  logic [63:0]       pc;
  logic              pc_valid, flush;
  logic [CNT_W-1:0]  taken_cnt;
  int checks = 0, errors = 0;

  pc_branch_sequencer #(.ADDR_W(64), .RESET_VECTOR(64'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid), .br_taken(br_taken),
    .br_pc(br_pc), .br_offset(br_offset), .pc(pc), .pc_valid(pc_valid), .flush(flush),
    .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: booting flag, optional pending redirect, plain arithmetic
  logic [63:0] m_pc, m_ptgt;
  bit          m_boot, m_pend;
  int          m_cnt;

  typedef struct {
    bit stall, bv, bt;
    logic [63:0] bpc, boff, pc;
    bit valid, flush;
    int cnt;
  } vec_t;
  vec_t vecs[19];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit m_take();
    return br_valid && br_taken && !m_boot;
  endfunction

  task automatic model_reset();
    m_pc = 64'h0; m_ptgt = '0; m_boot = 1; m_pend = 0; m_cnt = 0;
  endtask

  task automatic check_model();
    chk("pc", pc, m_pc);
    chk("pc_valid", 64'(pc_valid), 64'(!m_boot && !m_pend));
    chk("flush", 64'(flush), 64'(m_take()));
    chk("taken_cnt", 64'(taken_cnt), 64'(m_cnt));
  endtask

  task automatic model_clock();
    bit t;
    logic [63:0] tg;
    t  = m_take();
    tg = br_pc + br_offset * 64'd4;
    if (t && m_cnt < CMAX) m_cnt++;
    if (m_boot) m_boot = 0;
    else if (m_pend) begin
      if (t) m_ptgt = tg;
      if (!stall) begin m_pc = t ? tg : m_ptgt; m_pend = 0; end
    end else if (t && stall) begin m_pend = 1; m_ptgt = tg; end
    else if (t) m_pc = tg;
    else if (!stall) m_pc = m_pc + 64'd4;
  endtask

  // Called at posedge+1: apply inputs, check mid-cycle, advance model across the edge
  task automatic step(bit s, bit v, bit tk, logic [63:0] bp, logic [63:0] bo);
    stall = s; br_valid = v; br_taken = tk; br_pc = bp; br_offset = bo;
    #3;
    check_model();
    model_clock();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; stall = 0; br_valid = 0; br_taken = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pc", pc, 64'h0);
    chk("reset_valid", 64'(pc_valid), 64'h0);
    chk("reset_cnt", 64'(taken_cnt), 64'h0);
    reset = 0;
    model_reset();
  endtask

  initial begin
    // {stall,bv,bt,br_pc,br_offset, expected pc,pc_valid,flush,taken_cnt} sampled before the edge
    vecs[0]  = '{0,0,0,64'h0,64'h0,64'h0,0,0,0};
    vecs[1]  = '{0,0,0,64'h0,64'h0,64'h0,1,0,0};
    vecs[2]  = '{0,0,0,64'h0,64'h0,64'h4,1,0,0};
    vecs[3]  = '{0,0,0,64'h0,64'h0,64'h8,1,0,0};
    vecs[4]  = '{0,1,1,64'h0,64'h40,64'hC,1,1,0};
    vecs[5]  = '{0,1,1,64'hF8,64'h10,64'h100,1,1,1};
    vecs[6]  = '{0,1,0,64'h0,64'h40,64'h138,1,0,2};
    vecs[7]  = '{0,1,1,64'h1000,64'hFFFF_FFFF_FFFF_FFFE,64'h13C,1,1,2};
    vecs[8]  = '{0,1,1,64'hFFFF_FFFF_FFFF_FFFC,64'h1,64'hFF8,1,1,3};
    vecs[9]  = '{0,0,0,64'h0,64'h0,64'h0,1,0,4};
    vecs[10] = '{0,0,0,64'h0,64'h0,64'h4,1,0,4};
    vecs[11] = '{1,1,1,64'hF8,64'h10,64'h8,1,1,4};
    vecs[12] = '{1,0,0,64'h0,64'h0,64'h8,0,0,5};
    vecs[13] = '{1,0,0,64'h0,64'h0,64'h8,0,0,5};
    vecs[14] = '{0,0,0,64'h0,64'h0,64'h8,0,0,5};
    vecs[15] = '{1,1,1,64'h0,64'h100,64'h138,1,1,5};
    vecs[16] = '{0,1,1,64'h0,64'h200,64'h138,0,1,6};
    vecs[17] = '{0,0,0,64'h0,64'h0,64'h800,1,0,7};
    vecs[18] = '{0,0,0,64'h0,64'h0,64'h804,1,0,7};

    do_reset();
    foreach (vecs[i]) begin
      stall = vecs[i].stall; br_valid = vecs[i].bv; br_taken = vecs[i].bt;
      br_pc = vecs[i].bpc; br_offset = vecs[i].boff;
      #3;
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].pc);
      chk($sformatf("vec%0d_valid", i), 64'(pc_valid), 64'(vecs[i].valid));
      chk($sformatf("vec%0d_flush", i), 64'(flush), 64'(vecs[i].flush));
      chk($sformatf("vec%0d_cnt", i), 64'(taken_cnt), 64'(vecs[i].cnt));
      @(posedge clk); #1;
    end

    // Taken branch during BOOT is ignored
    do_reset();
    step(0, 1, 1, 64'h500, 64'h10);
    chk("boot_ignore_pc", pc, 64'h0);
    chk("boot_ignore_cnt", 64'(taken_cnt), 64'h0);

    // Async reset while PEND discards the pending target
    step(1, 1, 1, 64'h2000, 64'h4);
    step(1, 0, 0, 64'h0, 64'h0);
    br_valid = 1; br_taken = 1; br_pc = 64'h3000; stall = 1;
    #1 reset = 1;
    #1;
    chk("async_rst_pc", pc, 64'h0);
    chk("async_rst_valid", 64'(pc_valid), 64'h0);
    chk("async_rst_flush", 64'(flush), 64'h0);
    chk("async_rst_cnt", 64'(taken_cnt), 64'h0);
    @(posedge clk); #1;
    reset = 0; model_reset();
    step(0, 0, 0, 64'h0, 64'h0);
    step(0, 0, 0, 64'h0, 64'h0);
    step(0, 0, 0, 64'h0, 64'h0);
    chk("after_pend_rst_pc", pc, 64'h8);

    // Counter saturates at all-ones
    do_reset();
    step(0, 0, 0, 64'h0, 64'h0);
    for (int i = 0; i < CMAX + 3; i++) begin
      chk("sat_cnt", 64'(taken_cnt), 64'(i < CMAX ? i : CMAX));
      step(0, 1, 1, 64'h0, 64'h0);
    end

    // Random stimulus against the model
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 250; c++)
        step($urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 2) != 0,
             {$urandom, $urandom}, (r[0] ? {$urandom, $urandom} : 64'($signed($urandom_range(0, 64)) - 32)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
